par16_rx_unpack: RTL and testbench

//  - Front end of the host link. Captures 16-bit words strobed in on the host parallel bus.
//  - Buffers them in a small FIFO and unpacks each word MSB byte first, then LSB byte.
//  - Output is the byte stream (rxd_data / rxd_data_ready) that cmd_parser consumes.
//  - Gives the host flow control (par_busy) and flushes on the parser's desync (CLOSE) pulse.

---
 rtl/par16_rx_unpack_pkg.sv | 15 +
 rtl/par16_rx_unpack_if.sv | 30 +++
 rtl/par_word_fifo.sv | 56 +++++
 rtl/par16_rx_unpack.sv | 180 ++++++++++++++++++
 tb/tb_par16_rx_unpack.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/par16_rx_unpack_pkg.sv
// Shared constants for the host parallel link.
package par16_rx_unpack_pkg;

  // Byte order on the link is MSB first: hold[15:8] leaves before hold[7:0].
  // The transmit packer packs in the same order, so both sides use word_byte().
  localparam int PAR_WIDTH  = 16;
  localparam int BYTE_WIDTH = 8;

  // Selects one byte of a word: lsb=0 gives the high byte, lsb=1 the low byte.
  function automatic logic [BYTE_WIDTH-1:0] word_byte(input logic [PAR_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? w[BYTE_WIDTH-1:0] : w[PAR_WIDTH-1:BYTE_WIDTH];
  endfunction

endpackage

// File: rtl/par16_rx_unpack_if.sv
// Host parallel bus and parser byte stream bundled as one interface.
//
// Handshake: the host writes one word per rising edge of par_strobe, with
// par_data stable from one clk before the rise until the fall, and starts no new
// strobe while par_busy is high. Toward the parser there is no back-pressure:
// rxd_data is valid only in the single cycle rxd_data_ready is high. desync is a
// one-cycle flush request from the parser. fsm_state exposes the unpacker state.
interface par16_rx_unpack_if;
  import par16_rx_unpack_pkg::*;

  logic [PAR_WIDTH-1:0]  par_data;
  logic                  par_strobe;
  logic                  par_busy;
  logic                  desync;
  logic [BYTE_WIDTH-1:0] rxd_data;
  logic                  rxd_data_ready;
  logic                  overflow;
  logic [1:0]            fsm_state;

  modport slave (
    input  par_data, par_strobe, desync,
    output par_busy, rxd_data, rxd_data_ready, overflow, fsm_state
  );

  modport master (
    output par_data, par_strobe, desync,
    input  par_busy, rxd_data, rxd_data_ready, overflow, fsm_state
  );

endinterface

// File: rtl/par_word_fifo.sv
// Synchronous word FIFO. rd_data always shows the head entry, so a word popped
// with rd_en is usable in that same cycle. Writes while full are ignored.
module par_word_fifo
  import par16_rx_unpack_pkg::*;
#(
  parameter int WIDTH = PAR_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers and fill count; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/par16_rx_unpack.sv
// Host link front end: synchronises the host strobe, buffers 16-bit words and
// emits them to the command parser as a byte stream, high byte first.
module par16_rx_unpack
  import par16_rx_unpack_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_FULL = FIFO_DEPTH - 2,
  parameter int BYTE_GAP    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  par16_rx_unpack_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_MSB  = 2'd1,
    U_LSB  = 2'd2,
    U_GAP  = 2'd3
  } u_state_t;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic [PAR_WIDTH-1:0]    data_pipe [SYNC_STAGES];
  logic                    edge_q;
  logic                    wr_en;
  logic                    pop;
  logic [PAR_WIDTH-1:0]    fifo_rd_data;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic                    full;
  logic                    empty;
  logic                    busy_q;
  logic                    ovf_q;
  u_state_t                state_q, state_d;
  u_state_t                pend_q, pend_d;
  logic [PAR_WIDTH-1:0]    hold_q, hold_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [BYTE_WIDTH-1:0]   rxd_q, rxd_d;
  logic                    rdy_q, rdy_d;

  // Strobe synchroniser with a matching data delay so the captured word lines
  // up with the detected edge; edge_q keeps tracking through desync.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_pipe[i] <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.par_strobe};
      edge_q       <= sync_q[SYNC_STAGES-1];
      data_pipe[0] <= bus.par_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_pipe[i] <= data_pipe[i-1];
    end
  end

  // An edge seen in the desync cycle is thrown away along with the FIFO.
  assign wr_en = sync_q[SYNC_STAGES-1] && !edge_q && !bus.desync;

  par_word_fifo #(
    .WIDTH (PAR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.desync),
    .wr_en   (wr_en),
    .wr_data (data_pipe[SYNC_STAGES-1]),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Fill level after this cycle's push/pop/flush, used for the busy flag.
  always_comb begin
    count_next = count;
    if (bus.desync) count_next = '0;
    else            count_next = count + CW'(wr_en && !full) - CW'(pop);
  end

  // Host flow control and the sticky dropped-word flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (count_next >= CW'(ALMOST_FULL));
      if (bus.desync)          ovf_q <= 1'b0;
      else if (wr_en && full)  ovf_q <= 1'b1;
    end
  end

  // Unpacker state and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= U_IDLE;
      pend_q  <= U_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      rxd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rxd_q   <= rxd_d;
      rdy_q   <= rdy_d;
    end
  end

  // Unpacker next state: pop a word, send high byte, send low byte while
  // popping the next word, optionally idling BYTE_GAP cycles after each byte.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rxd_d   = rxd_q;
    rdy_d   = 1'b0;
    pop     = 1'b0;
    if (bus.desync) begin
      state_d = U_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        U_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            hold_d  = fifo_rd_data;
            state_d = U_MSB;
          end
        end
        U_MSB: begin
          rxd_d = word_byte(hold_q, 1'b0);
          rdy_d = 1'b1;
          if (BYTE_GAP > 0) begin
            pend_d  = U_LSB;
            gap_d   = '0;
            state_d = U_GAP;
          end else begin
            state_d = U_LSB;
          end
        end
        U_LSB: begin
          rxd_d = word_byte(hold_q, 1'b1);
          rdy_d = 1'b1;
          if (!empty) begin
            pop    = 1'b1;
            hold_d = fifo_rd_data;
          end
          if (BYTE_GAP > 0) begin
            pend_d  = empty ? U_IDLE : U_MSB;
            gap_d   = '0;
            state_d = U_GAP;
          end else begin
            state_d = empty ? U_IDLE : U_MSB;
          end
        end
        U_GAP: begin
          if (gap_q == GW'(BYTE_GAP - 1)) state_d = pend_q;
          else                            gap_d   = gap_q + GW'(1);
        end
        default: state_d = U_IDLE;
      endcase
    end
  end

  assign bus.par_busy       = busy_q;
  assign bus.overflow       = ovf_q;
  assign bus.rxd_data       = rxd_q;
  assign bus.rxd_data_ready = rdy_q;
  assign bus.fsm_state      = state_q;

endmodule

// File: tb/tb_par16_rx_unpack.sv
// Bench for par16_rx_unpack: dut0 runs with no byte gap, dut1 with a 15-cycle
// gap so its FIFO can be filled and overflowed.
module tb_par16_rx_unpack;
  import par16_rx_unpack_pkg::*;

  localparam int         SYNC    = 2;
  localparam int         AFULL   = 6;
  localparam logic [1:0] ST_MSB  = 2'd1;
  localparam logic [1:0] ST_LSB  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  par16_rx_unpack_if bus0 ();
  par16_rx_unpack_if bus1 ();

  par16_rx_unpack #(.FIFO_DEPTH(8), .SYNC_STAGES(SYNC), .ALMOST_FULL(AFULL), .BYTE_GAP(0))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  par16_rx_unpack #(.FIFO_DEPTH(8), .SYNC_STAGES(SYNC), .ALMOST_FULL(AFULL), .BYTE_GAP(15))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int pulse0_q[$];
  int pulse1_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // byte monitors: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (bus0.rxd_data_ready === 1'b1) begin
      pulse0_q.push_back(cyc);
      if (exp0_q.size() == 0) check_val("dut0_extra_byte", 32'(bus0.rxd_data_ready), 32'd0);
      else                    check_val("dut0_byte", 32'(bus0.rxd_data), 32'(exp0_q.pop_front()));
    end
    if (bus1.rxd_data_ready === 1'b1) begin
      pulse1_q.push_back(cyc);
      if (exp1_q.size() == 0) check_val("dut1_extra_byte", 32'(bus1.rxd_data_ready), 32'd0);
      else                    check_val("dut1_byte", 32'(bus1.rxd_data), 32'(exp1_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send0(input logic [15:0] w, input int hold);
    @(negedge clk) bus0.par_data = w;
    @(negedge clk) bus0.par_strobe = 1'b1;
    exp0_q.push_back(w[15:8]);
    exp0_q.push_back(w[7:0]);
    repeat (hold) @(negedge clk);
    bus0.par_strobe = 1'b0;
  endtask

  task automatic send1(input logic [15:0] w);
    @(negedge clk) bus1.par_data = w;
    @(negedge clk) bus1.par_strobe = 1'b1;
    exp1_q.push_back(w[15:8]);
    exp1_q.push_back(w[7:0]);
    @(negedge clk) bus1.par_strobe = 1'b0;
  endtask

  task automatic wait_drain0(input int budget);
    int n = 0;
    while (exp0_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("dut0_drain_left", 32'(exp0_q.size()), 32'd0);
  endtask

  task automatic wait_drain1(input int budget);
    int n = 0;
    while (exp1_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("dut1_drain_left", 32'(exp1_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int found;
    logic [15:0] w;
    bus0.par_data = '0; bus0.par_strobe = 1'b0; bus0.desync = 1'b0;
    bus1.par_data = '0; bus1.par_strobe = 1'b0; bus1.desync = 1'b0;

    // reset values
    tick(4);
    check_val("rst_busy0", 32'(bus0.par_busy), 32'd1);
    check_val("rst_rdy0", 32'(bus0.rxd_data_ready), 32'd0);
    check_val("rst_data0", 32'(bus0.rxd_data), 32'd0);
    check_val("rst_ovf0", 32'(bus0.overflow), 32'd0);
    check_val("rst_busy1", 32'(bus1.par_busy), 32'd1);
    check_val("rst_ovf1", 32'(bus1.overflow), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check_val("release_busy0", 32'(bus0.par_busy), 32'd0);
    check_val("release_busy1", 32'(bus1.par_busy), 32'd0);

    // single word: edge E = rise+SYNC+1, MSB at E+2, LSB at E+3
    pulse0_q.delete();
    @(negedge clk) bus0.par_data = 16'h0102;
    @(negedge clk) bus0.par_strobe = 1'b1;
    c = cyc;
    exp0_q.push_back(8'h01);
    exp0_q.push_back(8'h02);
    @(negedge clk) bus0.par_strobe = 1'b0;
    tick(15);
    check_val("t1_pulses", 32'(pulse0_q.size()), 32'd2);
    check_val("t1_msb_cycle", 32'(pulse0_q.size() > 0 ? pulse0_q[0] : -1), 32'(c + SYNC + 3));
    check_val("t1_lsb_cycle", 32'(pulse0_q.size() > 1 ? pulse0_q[1] : -1), 32'(c + SYNC + 4));
    check_val("t1_left", 32'(exp0_q.size()), 32'd0);

    // burst of six words, one every 4 clk
    for (int k = 0; k < 6; k++) begin
      send0(16'h0100 + 16'(k), 1);
      tick(1);
    end
    wait_drain0(100);
    check_val("t2_ovf0", 32'(bus0.overflow), 32'd0);
    check_val("t2_busy0", 32'(bus0.par_busy), 32'd0);

    // overflow on dut1: strobes every 2 clk. Word 1 goes straight to the hold
    // register, words 2..9 fill the 8 entries, word 10 meets a full FIFO.
    // At the rise of strobe k the FIFO holds max(k-3,0) words.
    pulse1_q.delete();
    c = 0;
    for (int k = 1; k <= 10; k++) begin
      w = 16'h3000 + 16'(k * 16'h0111);
      @(negedge clk);
      bus1.par_strobe = 1'b0;
      bus1.par_data = w;
      @(negedge clk);
      check_val("t3_busy_at_rise", 32'(bus1.par_busy), 32'(((k > 3 ? k - 3 : 0) >= AFULL) ? 1 : 0));
      if (k == 10) check_val("t3_ovf_before", 32'(bus1.overflow), 32'd0);
      bus1.par_strobe = 1'b1;
      if (k == 1) c = cyc;
      if (k <= 9) begin
        exp1_q.push_back(w[15:8]);
        exp1_q.push_back(w[7:0]);
      end
    end
    @(negedge clk) bus1.par_strobe = 1'b0;
    tick(3);
    check_val("t3_ovf_after", 32'(bus1.overflow), 32'd1);
    check_val("t3_busy_after", 32'(bus1.par_busy), 32'd1);
    wait_drain1(700);
    check_val("t3_gap_msb_cycle", 32'(pulse1_q.size() > 0 ? pulse1_q[0] : -1), 32'(c + SYNC + 3));
    check_val("t3_gap_lsb_cycle", 32'(pulse1_q.size() > 1 ? pulse1_q[1] : -1), 32'(c + SYNC + 4 + 15));
    tick(5);
    check_val("t3_ovf_sticky", 32'(bus1.overflow), 32'd1);

    // desync during U_LSB of the first of three queued words
    for (int k = 0; k < 3; k++) begin
      w = 16'h1234 + 16'(k * 16'h1111);
      @(negedge clk);
      bus1.par_strobe = 1'b0;
      bus1.par_data = w;
      @(negedge clk) bus1.par_strobe = 1'b1;
      exp1_q.push_back(w[15:8]);
      exp1_q.push_back(w[7:0]);
    end
    @(negedge clk) bus1.par_strobe = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus1.fsm_state == ST_LSB) begin
        found = 1;
        break;
      end
    end
    check_val("t4_reach_lsb", 32'(found), 32'd1);
    check_val("t4_pending", 32'(exp1_q.size()), 32'd5);
    bus1.desync = 1'b1;
    exp1_q.delete();
    @(negedge clk) bus1.desync = 1'b0;
    check_val("t4_rdy_after", 32'(bus1.rxd_data_ready), 32'd0);
    check_val("t4_ovf_cleared", 32'(bus1.overflow), 32'd0);
    check_val("t4_busy_after", 32'(bus1.par_busy), 32'd0);
    tick(40);
    send1(16'h0203);
    wait_drain1(100);

    // reset while dut0 sits in U_MSB: neither byte may appear
    send0(16'hA55A, 1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.fsm_state == ST_MSB) begin
        found = 1;
        break;
      end
    end
    check_val("t5_reach_msb", 32'(found), 32'd1);
    reset_n = 1'b0;
    exp0_q.delete();
    pulse0_q.delete();
    @(negedge clk);
    check_val("t5_rst_data0", 32'(bus0.rxd_data), 32'd0);
    check_val("t5_rst_rdy0", 32'(bus0.rxd_data_ready), 32'd0);
    check_val("t5_rst_ovf0", 32'(bus0.overflow), 32'd0);
    check_val("t5_rst_busy0", 32'(bus0.par_busy), 32'd1);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_val("t5_release_busy0", 32'(bus0.par_busy), 32'd0);
    tick(20);
    check_val("t5_no_bytes", 32'(pulse0_q.size()), 32'd0);

    // strobe held high for 20 clk: one word only
    pulse0_q.delete();
    send0(16'h3C5A, 20);
    wait_drain0(100);
    tick(10);
    check_val("t6_pulses", 32'(pulse0_q.size()), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
